fc_weight_sequencer: RTL and testbench
======================================

FC_WEIGHT_SEQUENCER -- requirements
Module: fc_weight_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, the width of the weight-memory row address.
REQ-002 SHALL have parameter LEN_WIDTH, default 10, the width of the row-count configuration.
REQ-003 SHALL have parameter PASS_WIDTH, default 8, the width of the pass-count configuration.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port start, input, 1 bit: a one-cycle request to begin a job.
REQ-007 SHALL have port abort, input, 1 bit: terminates the current job.
REQ-008 SHALL have port cfg_base, input, ADDR_WIDTH bits: the first row address.
REQ-009 SHALL have port cfg_len, input, LEN_WIDTH bits: the rows per pass, legal range 1..2^ADDR_WIDTH.
REQ-010 SHALL have port cfg_passes, input, PASS_WIDTH bits: the number of passes, legal range 1..2^PASS_WIDTH-1.
REQ-011 SHALL have port w_ready, input, 1 bit: the consumer (FC PE array) accepts the current weight row.
REQ-012 SHALL have port address_fc, output, ADDR_WIDTH bits: the weight-memory row address.
REQ-013 SHALL have port read_en_MM_fc, output, 1 bit: the memory read enable; 0 makes memory output zeros.
REQ-014 SHALL have port enable_MM_out_fc, output, 1 bit: the memory bus drive enable; 0 tri-states the bus.
REQ-015 SHALL have port w_valid, output, 1 bit: the weight bus holds the row at address_fc.
REQ-016 SHALL have port w_last, output, 1 bit: the current row is the last of the final pass.
REQ-017 SHALL have ports busy, done and cfg_err, output, 1 bit each: job active; one-cycle completion pulse; one-cycle illegal-configuration pulse.

Function
REQ-018 SHALL implement states IDLE, FILL, STREAM and DONE.
REQ-019 SHALL, in IDLE with start=1 and legal cfg, latch cfg_base, cfg_len and cfg_passes, load address_fc=cfg_base, and enter FILL.
REQ-020 SHALL, in IDLE with start=1 and cfg_len=0 or cfg_passes=0, pulse cfg_err for one cycle and stay in IDLE.
REQ-021 SHALL ignore start in any state other than IDLE.
REQ-022 SHALL hold FILL for exactly one cycle with read_en_MM_fc=1, enable_MM_out_fc=1 and w_valid=0, allowing the memory's falling-edge fetch, then enter STREAM.
REQ-023 SHALL, in STREAM, hold w_valid=1, read_en_MM_fc=1 and enable_MM_out_fc=1.
REQ-024 SHALL treat w_valid=1 with w_ready=1 on a rising edge as a transfer.
REQ-025 SHALL, on a transfer that is not the last row of a pass, increment address_fc by 1 and the row counter by 1.
REQ-026 SHALL wrap address_fc modulo 2^ADDR_WIDTH (for example 511 -> 0 at the default width).
REQ-027 SHALL, on a transfer of the last row of a non-final pass, reload address_fc=base, clear the row counter, increment the pass counter, and keep w_valid=1 with no bubble.
REQ-028 SHALL, on a transfer of the last row of the final pass, enter DONE.
REQ-029 SHALL, on a stall (w_valid=1, w_ready=0), hold address_fc and all counters, so the memory re-fetches the same row and the data stays stable.
REQ-030 SHALL drive w_last=1 only in STREAM when the row counter equals len-1 and the pass counter equals passes-1.
REQ-031 SHALL make DONE last one cycle with done=1, w_valid=0 and the enables at 0, then enter IDLE.
REQ-032 SHALL, in IDLE, drive read_en_MM_fc=0, enable_MM_out_fc=0 and w_valid=0, releasing the bus.
REQ-033 SHALL, on abort=1 in FILL or STREAM, enter IDLE on the next edge with w_valid=0 and without pulsing done.
REQ-034 SHALL give abort priority over a simultaneous transfer.
REQ-035 SHALL assert busy=1 in FILL and STREAM, and busy=0 in IDLE and DONE.
REQ-036 SHALL make the latency from accepted start to first w_valid exactly 2 cycles.
REQ-037 SHALL, when the consumer never stalls, complete a job in len*passes+3 cycles from start to done.
REQ-038 SHALL register all outputs and SHALL have no combinational path from input to output.

Reset
REQ-039 SHALL, when reset=0 at a rising edge, enter IDLE and set address_fc=0, read_en_MM_fc=0, enable_MM_out_fc=0, w_valid=0, w_last=0, busy=0, done=0, cfg_err=0, and all counters to 0.
REQ-040 SHALL give reset priority over start and abort, and SHALL abort any job in progress when reset is asserted mid-job.

Verification
REQ-041 SHALL verify a basic stream: base=10, len=4, passes=1, w_ready=1 -> address_fc 10,11,12,13 with w_valid; w_last with 13; done 7 cycles after start.
REQ-042 SHALL verify multi-pass operation: base=0, len=3, passes=2 -> addresses 0,1,2,0,1,2 with no bubble; w_last only on the second 2.
REQ-043 SHALL verify stall behaviour: w_ready low for 3 cycles while at address 5 -> address_fc stays 5, w_valid stays 1, the weight bus is unchanged, and the counters are frozen.
REQ-044 SHALL verify wrap-around: base=510, len=4 -> addresses 510,511,0,1.
REQ-045 SHALL verify abort and illegal configuration: abort in STREAM -> IDLE next cycle, enables 0, no done; start with cfg_len=0 -> cfg_err for 1 cycle and busy stays 0.
REQ-046 SHALL verify reset mid-job: reset=0 during STREAM -> all outputs at reset values on the next edge; a new start is accepted normally after release.

Source files
------------

// File: rtl/fc_weight_sequencer.sv
// Weight-row sequencer for the fully-connected PE array.
// Walks a block of cfg_len rows starting at cfg_base, cfg_passes times, and
// drives the weight-memory address and enables plus a valid/ready handshake
// towards the consumer. Every output comes straight from a flop.
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | bus released, waiting for start
// FILL   | one cycle with the memory enabled so the first row is fetched
// STREAM | w_valid high, one row per w_ready, rows wrap back to base per pass
// DONE   | one-cycle completion pulse, bus released
module fc_weight_sequencer #(
    parameter int ADDR_WIDTH = 9,
    parameter int LEN_WIDTH  = 10,
    parameter int PASS_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [PASS_WIDTH-1:0] cfg_passes,
    input  logic                  w_ready,
    output logic [ADDR_WIDTH-1:0] address_fc,
    output logic                  read_en_MM_fc,
    output logic                  enable_MM_out_fc,
    output logic                  w_valid,
    output logic                  w_last,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    // A pass may cover the whole address space but no more.
    localparam int unsigned MAX_LEN = 2 ** ADDR_WIDTH;

    state_t                state_q;
    state_t                state_d;

    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] base_d;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  len_d;
    logic [PASS_WIDTH-1:0] passes_q;
    logic [PASS_WIDTH-1:0] passes_d;

    logic [ADDR_WIDTH-1:0] addr_d;
    logic [LEN_WIDTH-1:0]  row_q;
    logic [LEN_WIDTH-1:0]  row_d;
    logic [PASS_WIDTH-1:0] pass_q;
    logic [PASS_WIDTH-1:0] pass_d;

    logic                  cfg_ok;
    logic                  xfer;
    logic                  row_last;
    logic                  pass_last;
    logic                  cfg_err_d;
    logic                  w_last_d;

    // Configuration legality and end-of-row / end-of-pass detection.
    always_comb begin
        cfg_ok    = (cfg_len != '0) && (cfg_passes != '0) &&
                    (32'(cfg_len) <= MAX_LEN);
        xfer      = w_valid && w_ready;
        row_last  = (row_q == (len_q - LEN_WIDTH'(1)));
        pass_last = (pass_q == (passes_q - PASS_WIDTH'(1)));
    end

    // Next-state and datapath update; abort wins over a same-cycle transfer.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        len_d     = len_q;
        passes_d  = passes_q;
        addr_d    = address_fc;
        row_d     = row_q;
        pass_d    = pass_q;
        cfg_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        base_d   = cfg_base;
                        len_d    = cfg_len;
                        passes_d = cfg_passes;
                        addr_d   = cfg_base;
                        row_d    = '0;
                        pass_d   = '0;
                        state_d  = FILL;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end

            FILL: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    state_d = STREAM;
                end
            end

            STREAM: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (xfer) begin
                    if (row_last) begin
                        if (pass_last) begin
                            state_d = DONE;
                        end else begin
                            // Rewind for the next pass without dropping valid.
                            addr_d = base_q;
                            row_d  = '0;
                            pass_d = pass_q + PASS_WIDTH'(1);
                        end
                    end else begin
                        addr_d = address_fc + ADDR_WIDTH'(1);
                        row_d  = row_q + LEN_WIDTH'(1);
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // w_last is decoded from the next state so it can be registered with it.
    always_comb begin
        w_last_d = (state_d == STREAM) &&
                   (row_d == (len_d - LEN_WIDTH'(1))) &&
                   (pass_d == (passes_d - PASS_WIDTH'(1)));
    end

    // State, latched configuration, address and counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            passes_q   <= '0;
            address_fc <= '0;
            row_q      <= '0;
            pass_q     <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            passes_q   <= passes_d;
            address_fc <= addr_d;
            row_q      <= row_d;
            pass_q     <= pass_d;
        end
    end

    // Registered handshake, memory enables and status flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            read_en_MM_fc    <= 1'b0;
            enable_MM_out_fc <= 1'b0;
            w_valid          <= 1'b0;
            w_last           <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            cfg_err          <= 1'b0;
        end else begin
            read_en_MM_fc    <= (state_d == FILL) || (state_d == STREAM);
            enable_MM_out_fc <= (state_d == FILL) || (state_d == STREAM);
            w_valid          <= (state_d == STREAM);
            w_last           <= w_last_d;
            busy             <= (state_d == FILL) || (state_d == STREAM);
            done             <= (state_d == DONE);
            cfg_err          <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_fc_weight_sequencer.sv
// Self-checking bench for fc_weight_sequencer.
// Expected address streams are built from the job description alone:
// row k of the job is (base + k mod len) mod 2^ADDR_WIDTH, and the last of
// len*passes rows carries w_last. Cycle numbering: the cycle in which start
// is high is cycle 0, so the first valid row appears in cycle 2 and done
// appears in cycle len*passes+stalls+2 (the len*passes+stalls+3'th cycle
// of the job when the start cycle is counted as the first).
module tb_fc_weight_sequencer;

    localparam int AW   = 9;
    localparam int LW   = 10;
    localparam int PW   = 8;
    localparam int AMOD = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [AW-1:0] cfg_base;
    logic [LW-1:0] cfg_len;
    logic [PW-1:0] cfg_passes;
    logic          w_ready;
    logic [AW-1:0] address_fc;
    logic          read_en_MM_fc;
    logic          enable_MM_out_fc;
    logic          w_valid;
    logic          w_last;
    logic          busy;
    logic          done;
    logic          cfg_err;
    wire  [15:0]   w_bus;

    int errors = 0;
    int checks = 0;

    fc_weight_sequencer #(
        .ADDR_WIDTH(AW),
        .LEN_WIDTH (LW),
        .PASS_WIDTH(PW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .cfg_base        (cfg_base),
        .cfg_len         (cfg_len),
        .cfg_passes      (cfg_passes),
        .w_ready         (w_ready),
        .address_fc      (address_fc),
        .read_en_MM_fc   (read_en_MM_fc),
        .enable_MM_out_fc(enable_MM_out_fc),
        .w_valid         (w_valid),
        .w_last          (w_last),
        .busy            (busy),
        .done            (done),
        .cfg_err         (cfg_err)
    );

    always #5 clk = ~clk;

    // Weight memory: content is a fixed function of the row address.
    function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
        return {7'h5A, a} ^ 16'h3C3C;
    endfunction

    assign w_bus = enable_MM_out_fc ? (read_en_MM_fc ? mem_word(address_fc) : 16'h0000)
                                    : 16'hzzzz;

    // Observations collected by capture_job.
    int          c_addr[$];
    bit          c_last[$];
    bit          c_ready[$];
    logic [15:0] c_data[$];
    int          c_first_valid;
    int          c_done_cyc;
    int          c_done_count;
    int          c_gaps;
    int          c_stray_last;
    int          c_cfg_err_count;
    bit          c_fill_ok;
    bit          c_idle_ok;
    bit          c_timeout;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one job and records what the DUT does; it makes no judgements.
    // mode 0: always ready, 1: random stalls, 2: three stalls at stall_addr.
    task automatic capture_job(input int base, input int len, input int passes,
                               input int mode, input int stall_addr, input bit noisy_start);
        int cyc;
        int stall_left;
        bit r;
        c_addr.delete(); c_last.delete(); c_ready.delete(); c_data.delete();
        c_first_valid = -1; c_done_cyc = -1; c_done_count = 0; c_gaps = 0;
        c_stray_last = 0; c_cfg_err_count = 0; c_fill_ok = 0; c_idle_ok = 0; c_timeout = 0;
        stall_left = 3;
        cyc = 0;
        cfg_base   = AW'(base);
        cfg_len    = LW'(len);
        cfg_passes = PW'(passes);
        start      = 1'b1;
        abort      = 1'b0;
        w_ready    = 1'b1;
        while (1) begin
            tick();
            cyc++;
            start = 1'b0;
            if (cyc == 1)
                c_fill_ok = busy && read_en_MM_fc && enable_MM_out_fc && !w_valid;
            if (done) begin
                c_done_count++;
                if (c_done_cyc < 0) c_done_cyc = cyc;
            end
            if (cfg_err) c_cfg_err_count++;
            if (w_last && !w_valid) c_stray_last++;
            if (c_first_valid >= 0 && c_done_cyc < 0 && !w_valid) c_gaps++;
            if (c_done_cyc >= 0 && cyc == c_done_cyc + 1) begin
                c_idle_ok = !busy && !w_valid && !read_en_MM_fc && !enable_MM_out_fc && !done;
                break;
            end
            if (cyc > 2000) begin
                c_timeout = 1;
                break;
            end
            if (w_valid) begin
                if (c_first_valid < 0) c_first_valid = cyc;
                if (mode == 0) r = 1'b1;
                else if (mode == 1) r = ($urandom_range(0, 9) > 2);
                else if (int'(address_fc) == stall_addr && stall_left > 0) begin
                    r = 1'b0;
                    stall_left--;
                end else r = 1'b1;
                c_addr.push_back(int'(address_fc));
                c_last.push_back(w_last);
                c_ready.push_back(r);
                c_data.push_back(w_bus);
                w_ready = r;
                if (noisy_start) begin
                    start      = 1'b1;
                    cfg_base   = AW'($urandom);
                    cfg_len    = LW'($urandom_range(0, 3));
                    cfg_passes = PW'($urandom_range(0, 2));
                end
            end else begin
                w_ready = 1'b1;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; abort = 1'b0; w_ready = 1'b0;
        cfg_base = '0; cfg_len = '0; cfg_passes = '0;
        tick();
        tick();
        checks++; if (address_fc !== '0) begin errors++; $display("FAIL reset_addr: got %0d want 0", address_fc); end
        checks++; if (read_en_MM_fc !== 1'b0) begin errors++; $display("FAIL reset_read_en: got %b want 0", read_en_MM_fc); end
        checks++; if (enable_MM_out_fc !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b want 0", enable_MM_out_fc); end
        checks++; if (w_valid !== 1'b0) begin errors++; $display("FAIL reset_w_valid: got %b want 0", w_valid); end
        checks++; if (w_last !== 1'b0) begin errors++; $display("FAIL reset_w_last: got %b want 0", w_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b want 0", cfg_err); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        capture_job(10, 4, 1, 0, 0, 0);
        checks++; if (c_timeout) begin errors++; $display("FAIL basic_timeout: job did not finish"); end
        checks++; if (!c_fill_ok) begin errors++; $display("FAIL basic_fill: FILL cycle outputs wrong (want busy/enables 1, w_valid 0)"); end
        checks++; if (c_first_valid !== 2) begin errors++; $display("FAIL basic_latency: first w_valid in cycle %0d want 2", c_first_valid); end
        checks++; if (c_addr.size() !== 4) begin errors++; $display("FAIL basic_rows: got %0d rows want 4", c_addr.size()); end
        for (int i = 0; i < c_addr.size() && i < 4; i++) begin
            checks++;
            if (c_addr[i] !== 10 + i || c_last[i] !== (i == 3)) begin
                errors++;
                $display("FAIL basic_row%0d: addr=%0d last=%0b want addr=%0d last=%0b", i, c_addr[i], c_last[i], 10 + i, (i == 3));
            end
        end
        checks++; if (c_done_cyc !== 6) begin errors++; $display("FAIL basic_done_cycle: got %0d want 6", c_done_cyc); end
        checks++; if (!c_idle_ok) begin errors++; $display("FAIL basic_idle: outputs not released after done"); end
    endtask

    task automatic test_multipass();
        int exp_a[6] = '{0, 1, 2, 0, 1, 2};
        capture_job(0, 3, 2, 0, 0, 0);
        checks++; if (c_addr.size() !== 6) begin errors++; $display("FAIL multi_rows: got %0d rows want 6", c_addr.size()); end
        for (int i = 0; i < c_addr.size() && i < 6; i++) begin
            checks++;
            if (c_addr[i] !== exp_a[i] || c_last[i] !== (i == 5)) begin
                errors++;
                $display("FAIL multi_row%0d: addr=%0d last=%0b want addr=%0d last=%0b", i, c_addr[i], c_last[i], exp_a[i], (i == 5));
            end
        end
        checks++; if (c_gaps !== 0) begin errors++; $display("FAIL multi_bubble: got %0d bubbles want 0", c_gaps); end
        checks++; if (c_done_cyc !== 8) begin errors++; $display("FAIL multi_done_cycle: got %0d want 8", c_done_cyc); end
    endtask

    task automatic test_stall();
        int exp_a[9] = '{3, 4, 5, 5, 5, 5, 6, 7, 8};
        int at5;
        capture_job(3, 6, 1, 2, 5, 0);
        checks++; if (c_addr.size() !== 9) begin errors++; $display("FAIL stall_rows: got %0d valid cycles want 9", c_addr.size()); end
        at5 = 0;
        for (int i = 0; i < c_addr.size() && i < 9; i++) begin
            checks++;
            if (c_addr[i] !== exp_a[i]) begin
                errors++;
                $display("FAIL stall_row%0d: addr=%0d want %0d", i, c_addr[i], exp_a[i]);
            end
            if (c_addr[i] == 5) begin
                at5++;
                checks++;
                if (c_data[i] !== mem_word(AW'(5))) begin
                    errors++;
                    $display("FAIL stall_data%0d: bus=%h want %h", i, c_data[i], mem_word(AW'(5)));
                end
            end
        end
        checks++; if (at5 !== 4) begin errors++; $display("FAIL stall_hold: address 5 held %0d cycles want 4", at5); end
        checks++; if (c_gaps !== 0) begin errors++; $display("FAIL stall_valid_drop: got %0d cycles without w_valid want 0", c_gaps); end
        checks++; if (c_done_cyc !== 11) begin errors++; $display("FAIL stall_done_cycle: got %0d want 11", c_done_cyc); end
    endtask

    task automatic test_wrap();
        int exp_a[4] = '{510, 511, 0, 1};
        capture_job(510, 4, 1, 0, 0, 0);
        checks++; if (c_addr.size() !== 4) begin errors++; $display("FAIL wrap_rows: got %0d rows want 4", c_addr.size()); end
        for (int i = 0; i < c_addr.size() && i < 4; i++) begin
            checks++;
            if (c_addr[i] !== exp_a[i] || c_last[i] !== (i == 3)) begin
                errors++;
                $display("FAIL wrap_row%0d: addr=%0d last=%0b want addr=%0d last=%0b", i, c_addr[i], c_last[i], exp_a[i], (i == 3));
            end
        end
    endtask

    task automatic test_illegal_cfg();
        int lens[2]   = '{0, 3};
        int passes[2] = '{2, 0};
        for (int k = 0; k < 2; k++) begin
            cfg_base = AW'(7); cfg_len = LW'(lens[k]); cfg_passes = PW'(passes[k]);
            start = 1'b1;
            tick();
            start = 1'b0;
            checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL illegal%0d_err: cfg_err=%b want 1", k, cfg_err); end
            checks++; if (busy !== 1'b0 || w_valid !== 1'b0) begin errors++; $display("FAIL illegal%0d_busy: busy=%b w_valid=%b want 0 0", k, busy, w_valid); end
            tick();
            checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL illegal%0d_pulse: cfg_err=%b want 0", k, cfg_err); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL illegal%0d_idle: busy=%b want 0", k, busy); end
        end
    endtask

    task automatic test_abort();
        bit found;
        bit saw_done;
        // Abort mid-stream.
        cfg_base = AW'(20); cfg_len = LW'(8); cfg_passes = PW'(2);
        start = 1'b1; w_ready = 1'b1; abort = 1'b0;
        tick();
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (w_valid && address_fc == AW'(23)) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL abort_reach: address 23 never shown"); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (w_valid !== 1'b0 || busy !== 1'b0 || read_en_MM_fc !== 1'b0 || enable_MM_out_fc !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_stream: valid=%b busy=%b rd=%b en=%b done=%b want all 0", w_valid, busy, read_en_MM_fc, enable_MM_out_fc, done);
        end
        saw_done = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done || w_valid) saw_done = 1;
        end
        checks++; if (saw_done) begin errors++; $display("FAIL abort_no_done: done or w_valid seen after abort"); end

        // Abort on the final row while the consumer is ready.
        cfg_base = AW'(50); cfg_len = LW'(2); cfg_passes = PW'(1);
        start = 1'b1; w_ready = 1'b1;
        tick();
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (w_last) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL abort_last_reach: w_last never shown"); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (done !== 1'b0 || busy !== 1'b0 || w_valid !== 1'b0) begin errors++; $display("FAIL abort_priority: done=%b busy=%b valid=%b want 0 0 0", done, busy, w_valid); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_priority_late: done=%b want 0", done); end

        // Abort during FILL.
        cfg_base = AW'(60); cfg_len = LW'(3); cfg_passes = PW'(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1 || w_valid !== 1'b0) begin errors++; $display("FAIL fill_state: busy=%b valid=%b want 1 0", busy, w_valid); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || w_valid !== 1'b0 || enable_MM_out_fc !== 1'b0) begin errors++; $display("FAIL abort_fill: busy=%b valid=%b en=%b want 0 0 0", busy, w_valid, enable_MM_out_fc); end
        saw_done = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done || w_valid) saw_done = 1;
        end
        checks++; if (saw_done) begin errors++; $display("FAIL abort_fill_quiet: done or w_valid seen after abort"); end
    endtask

    task automatic test_reset_mid_job();
        bit found;
        cfg_base = AW'(40); cfg_len = LW'(8); cfg_passes = PW'(1);
        start = 1'b1; w_ready = 1'b1; abort = 1'b0;
        tick();
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (w_valid && address_fc == AW'(43)) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL rst_mid_reach: address 43 never shown"); end
        reset = 1'b0;
        tick();
        checks++;
        if (address_fc !== '0 || read_en_MM_fc !== 1'b0 || enable_MM_out_fc !== 1'b0 || w_valid !== 1'b0 ||
            w_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs: addr=%0d rd=%b en=%b valid=%b last=%b busy=%b done=%b err=%b want all 0",
                     address_fc, read_en_MM_fc, enable_MM_out_fc, w_valid, w_last, busy, done, cfg_err);
        end
        reset = 1'b1;
        tick();
        capture_job(7, 2, 1, 0, 0, 0);
        checks++; if (c_addr.size() !== 2) begin errors++; $display("FAIL rst_restart_rows: got %0d rows want 2", c_addr.size()); end
        for (int i = 0; i < c_addr.size() && i < 2; i++) begin
            checks++;
            if (c_addr[i] !== 7 + i) begin errors++; $display("FAIL rst_restart_row%0d: addr=%0d want %0d", i, c_addr[i], 7 + i); end
        end
        checks++; if (c_done_cyc !== 4) begin errors++; $display("FAIL rst_restart_done: got %0d want 4", c_done_cyc); end
    endtask

    // Back-to-back random jobs with random stalls and start/cfg noise mid-job.
    task automatic test_random_jobs();
        int base, len, passes, total, idx, stalls, exp_a;
        bit exp_l, noisy;
        for (int j = 0; j < 12; j++) begin
            base   = $urandom_range(0, AMOD - 1);
            len    = $urandom_range(1, 10);
            passes = $urandom_range(1, 3);
            noisy  = $urandom_range(0, 1);
            total  = len * passes;
            capture_job(base, len, passes, 1, 0, noisy);
            idx = 0;
            stalls = 0;
            for (int i = 0; i < c_addr.size(); i++) begin
                exp_a = (base + idx % len) % AMOD;
                exp_l = (idx == total - 1);
                checks++;
                if (c_addr[i] !== exp_a || c_last[i] !== exp_l) begin
                    errors++;
                    $display("FAIL rand%0d_cycle%0d: addr=%0d last=%0b want addr=%0d last=%0b", j, i, c_addr[i], c_last[i], exp_a, exp_l);
                end
                if (c_ready[i]) idx++;
                else stalls++;
            end
            checks++; if (c_timeout) begin errors++; $display("FAIL rand%0d_timeout: job did not finish", j); end
            checks++; if (idx !== total) begin errors++; $display("FAIL rand%0d_count: %0d rows transferred want %0d", j, idx, total); end
            checks++; if (c_first_valid !== 2) begin errors++; $display("FAIL rand%0d_latency: first valid cycle %0d want 2", j, c_first_valid); end
            checks++; if (c_done_cyc !== total + stalls + 2) begin errors++; $display("FAIL rand%0d_done_cycle: got %0d want %0d", j, c_done_cyc, total + stalls + 2); end
            checks++; if (c_done_count !== 1) begin errors++; $display("FAIL rand%0d_done_pulses: got %0d want 1", j, c_done_count); end
            checks++; if (c_gaps !== 0 || c_stray_last !== 0) begin errors++; $display("FAIL rand%0d_bubbles: gaps=%0d stray_last=%0d want 0 0", j, c_gaps, c_stray_last); end
            checks++; if (c_cfg_err_count !== 0) begin errors++; $display("FAIL rand%0d_cfg_err: got %0d pulses want 0", j, c_cfg_err_count); end
            checks++; if (!c_idle_ok) begin errors++; $display("FAIL rand%0d_idle: outputs not released after done", j); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multipass();
        test_stall();
        test_wrap();
        test_illegal_cfg();
        test_abort();
        test_reset_mid_job();
        test_random_jobs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
